// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Hardwired Moore sequencer for the Mini SRC datapath. It runs the fetch
// steps, decodes the opcode in ir[31:27], runs the execute steps for that
// instruction and drives every datapath control strobe. It also tracks
// run/halt status and counts retired instructions.
//
// Ports
//   clk            rising-edge clock
//   clr            synchronous active-high reset; forces every strobe to 0
//   ir[31:0]       instruction register contents (opcode = ir[31:27])
//   con            CON_FF result, used by the branch in T7
//   stop           halt request, sampled only when an instruction completes
//   Gra..BAout     register select / encode strobes
//   MARin..CONin   register load enables
//   PCout..Cout    bus drivers (at most one per cycle)
//   pc_increment   PC += 1
//   read           MDR mux selects memory data
//   memoryRead/Write  RAM strobes
//   alu_control    ALU opcode (0 outside ALU steps)
//   run            1 while executing, 0 in HALT
//   instr_count    retired instruction count, wraps at 2^32
//
// Parameter
//   MEM_LATENCY    cycles memoryRead is held before data is valid (1..4)
// -----------------------------------------------------------------------------
module control_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        MARin, MDRin, IRin, RYin, PCin, HIin, LOin,
  output logic        Zhighin, Zlowin, InPortin, CONin,
  output logic        PCout, MDRout, HIout, LOout, Zhighout, Zlowout,
  output logic        InPortout, Cout,
  output logic        pc_increment,
  output logic        read,
  output logic        memoryRead, memoryWrite,
  output logic [4:0]  alu_control,
  output logic        run,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_T9, S_HALT
  } state_t;

  // Instruction classes: opcodes that share one execute sequence.
  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT,
    C_BR, C_JR, C_IN, C_MF, C_NOP, C_HALT
  } iclass_t;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  // Down-counter reload: the wait state exits when the counter reads 0,
  // so loading k-1 yields exactly k cycles of memoryRead.
  localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

  function automatic iclass_t classify(input logic [4:0] op);
    case (op)
      5'd0:                                   return C_LD;
      5'd1:                                   return C_LDI;
      5'd2:                                   return C_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
      5'd8, 5'd9, 5'd10, 5'd11:               return C_RTYPE;
      5'd12, 5'd13, 5'd14:                    return C_IMM;
      5'd15, 5'd16:                           return C_MULDIV;
      5'd17, 5'd18:                           return C_NEGNOT;
      5'd19:                                  return C_BR;
      5'd20:                                  return C_JR;
      5'd22:                                  return C_IN;
      5'd24, 5'd25:                           return C_MF;
      5'd26:                                  return C_NOP;
      default:                                return C_HALT;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] instr_count_q, instr_count_d;

  logic [4:0]  opcode;
  iclass_t     iclass;
  logic [4:0]  imm_alu;
  logic        last_step;
  logic        unused_ir_bits;

  assign opcode         = ir[31:27];
  assign iclass         = classify(opcode);
  assign imm_alu        = (opcode == 5'd12) ? ALU_ADD :
                          (opcode == 5'd13) ? ALU_AND : ALU_OR;
  assign unused_ir_bits = ^ir[26:0];

  // Final step of each class; leaving it retires the instruction.
  always_comb begin
    last_step = 1'b0;
    case (iclass)
      C_NOP:                    last_step = (state_q == S_T3);
      C_JR, C_IN, C_MF:         last_step = (state_q == S_T4);
      C_NEGNOT:                 last_step = (state_q == S_T5);
      C_RTYPE, C_IMM, C_LDI:    last_step = (state_q == S_T6);
      C_MULDIV, C_BR:           last_step = (state_q == S_T7);
      C_ST:                     last_step = (state_q == S_T8);
      C_LD:                     last_step = (state_q == S_T9);
      default:                  last_step = 1'b0;
    endcase
  end

  // Next state, memory wait counter and retire counter.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    instr_count_d = instr_count_q;
    case (state_q)
      S_T0: begin
        state_d = S_T1;
        wait_d  = LAT_M1;
      end
      S_T1: begin
        if (wait_q == 3'd0) state_d = S_T2;
        else                wait_d  = wait_q - 3'd1;
      end
      S_T2: state_d = S_T3;
      // The opcode is taken from ir as the fetch completes.
      S_T3: state_d = (iclass == C_HALT) ? S_HALT : S_T4;
      S_T4: state_d = S_T5;
      S_T5: state_d = S_T6;
      S_T6: begin
        state_d = S_T7;
        wait_d  = LAT_M1;
      end
      S_T7: begin
        if (iclass != C_LD || wait_q == 3'd0) state_d = S_T8;
        else                                  wait_d  = wait_q - 3'd1;
      end
      S_T8:    state_d = S_T9;
      S_T9:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    if (last_step) begin
      instr_count_d = instr_count_q + 32'd1;
      state_d       = stop ? S_HALT : S_T0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its _d input, independent of block order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= S_T0;
      wait_q        <= 3'd0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Strobe decode from state (plus opcode / con during execute).
  // NOTE: every output gets a default before the case so no path leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout}                          = '0;
    {MARin, MDRin, IRin, RYin, PCin, HIin, LOin}               = '0;
    {Zhighin, Zlowin, InPortin, CONin}                         = '0;
    {PCout, MDRout, HIout, LOout, Zhighout, Zlowout}           = '0;
    {InPortout, Cout, pc_increment, read}                      = '0;
    {memoryRead, memoryWrite}                                  = '0;
    alu_control = 5'd0;
    if (!clr) begin
      case (state_q)
        S_T0: begin PCout = 1'b1; MARin = 1'b1; pc_increment = 1'b1; end
        S_T1: memoryRead = 1'b1;
        S_T2: begin read = 1'b1; MDRin = 1'b1; end
        S_T3: begin MDRout = 1'b1; IRin = 1'b1; end
        S_T4: begin
          case (iclass)
            C_RTYPE, C_IMM: begin Grb = 1'b1; Rout = 1'b1; RYin = 1'b1; end
            C_LDI, C_LD, C_ST: begin
              Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; RYin = 1'b1;
            end
            C_MULDIV: begin Gra = 1'b1; Rout = 1'b1; RYin = 1'b1; end
            C_NEGNOT: begin
              Grb = 1'b1; Rout = 1'b1; alu_control = opcode; Zlowin = 1'b1;
            end
            C_BR: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            C_JR: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            C_IN: begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_MF: begin
              HIout = (opcode == 5'd24);
              LOout = (opcode != 5'd24);
              Gra   = 1'b1;
              Rin   = 1'b1;
            end
            default: ;
          endcase
        end
        S_T5: begin
          case (iclass)
            C_RTYPE: begin
              Grc = 1'b1; Rout = 1'b1; alu_control = opcode; Zlowin = 1'b1;
            end
            C_IMM: begin Cout = 1'b1; alu_control = imm_alu; Zlowin = 1'b1; end
            C_LDI, C_LD, C_ST: begin
              Cout = 1'b1; alu_control = ALU_ADD; Zlowin = 1'b1;
            end
            C_MULDIV: begin
              Grb = 1'b1; Rout = 1'b1; alu_control = opcode;
              Zlowin = 1'b1; Zhighin = 1'b1;
            end
            C_NEGNOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_BR:     begin PCout = 1'b1; RYin = 1'b1; end
            default: ;
          endcase
        end
        S_T6: begin
          case (iclass)
            C_RTYPE, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
            C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; end
            C_BR: begin Cout = 1'b1; alu_control = ALU_ADD; Zlowin = 1'b1; end
            default: ;
          endcase
        end
        S_T7: begin
          case (iclass)
            C_LD:     memoryRead = 1'b1;
            // Register data goes to MDR from the bus, so read stays 0.
            C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
            C_BR:     begin Zlowout = con; PCin = con; end
            default: ;
          endcase
        end
        S_T8: begin
          case (iclass)
            C_LD:    begin read = 1'b1; MDRin = 1'b1; end
            C_ST:    memoryWrite = 1'b1;
            default: ;
          endcase
        end
        S_T9: begin
          if (iclass == C_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        end
        default: ;
      endcase
    end
  end

  assign run         = (state_q != S_HALT);
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  typedef struct packed {
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic MARin, MDRin, IRin, RYin, PCin, HIin, LOin, Zhighin, Zlowin, InPortin, CONin;
    logic PCout, MDRout, HIout, LOout, Zhighout, Zlowout, InPortout, Cout;
    logic pc_increment, read, memoryRead, memoryWrite;
    logic [4:0] alu;
    logic run;
  } strobes_t;

  typedef struct {
    logic [31:0] ir;
    bit          con;
    int          cyc1;
    int          cyc3;
    bit          halts;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr, con, stop;
  logic [31:0] ir;
  bit          sel;            // 0: MEM_LATENCY=1 instance, 1: MEM_LATENCY=3
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_count;
  strobes_t    exp_q[$];
  vec_t        vecs[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    strobes_t    o;
    logic [31:0] cnt;
    control_unit #(.MEM_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .clr(clr), .ir(ir), .con(con), .stop(stop),
      .Gra(o.Gra), .Grb(o.Grb), .Grc(o.Grc), .Rin(o.Rin), .Rout(o.Rout), .BAout(o.BAout),
      .MARin(o.MARin), .MDRin(o.MDRin), .IRin(o.IRin), .RYin(o.RYin), .PCin(o.PCin),
      .HIin(o.HIin), .LOin(o.LOin), .Zhighin(o.Zhighin), .Zlowin(o.Zlowin),
      .InPortin(o.InPortin), .CONin(o.CONin),
      .PCout(o.PCout), .MDRout(o.MDRout), .HIout(o.HIout), .LOout(o.LOout),
      .Zhighout(o.Zhighout), .Zlowout(o.Zlowout), .InPortout(o.InPortout), .Cout(o.Cout),
      .pc_increment(o.pc_increment), .read(o.read),
      .memoryRead(o.memoryRead), .memoryWrite(o.memoryWrite),
      .alu_control(o.alu), .run(o.run), .instr_count(cnt)
    );
  end

  function automatic strobes_t obs();
    return sel ? g_dut[1].o : g_dut[0].o;
  endfunction

  function automatic logic [31:0] obs_cnt();
    return sel ? g_dut[1].cnt : g_dut[0].cnt;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the per-cycle strobe list of one whole instruction,
  // written straight from the step tables (fetch, then the execute steps).
  // ---------------------------------------------------------------------------
  function automatic strobes_t blank();
    strobes_t s = '0;
    s.run = 1'b1;
    return s;
  endfunction

  // Returns 1 when the opcode sends the machine to HALT after fetch.
  function automatic bit build(input logic [4:0] op, input int lat, input bit c);
    strobes_t s;
    bit       halts = 1'b0;
    exp_q.delete();
    s = blank(); s.PCout = 1; s.MARin = 1; s.pc_increment = 1; exp_q.push_back(s);
    for (int i = 0; i < lat; i++) begin s = blank(); s.memoryRead = 1; exp_q.push_back(s); end
    s = blank(); s.read = 1; s.MDRin = 1; exp_q.push_back(s);
    s = blank(); s.MDRout = 1; s.IRin = 1; exp_q.push_back(s);
    if (op inside {[5'd3:5'd14]}) begin
      s = blank(); s.Grb = 1; s.Rout = 1; s.RYin = 1; exp_q.push_back(s);
      s = blank(); s.Zlowin = 1;
      if (op <= 5'd11) begin s.Grc = 1; s.Rout = 1; s.alu = op; end
      else begin
        s.Cout = 1;
        s.alu  = (op == 5'd12) ? 5'b00011 : (op == 5'd13) ? 5'b00101 : 5'b00110;
      end
      exp_q.push_back(s);
      s = blank(); s.Zlowout = 1; s.Gra = 1; s.Rin = 1; exp_q.push_back(s);
    end else if (op <= 5'd2) begin
      s = blank(); s.Grb = 1; s.Rout = 1; s.BAout = 1; s.RYin = 1; exp_q.push_back(s);
      s = blank(); s.Cout = 1; s.alu = 5'b00011; s.Zlowin = 1; exp_q.push_back(s);
      if (op == 5'd1) begin
        s = blank(); s.Zlowout = 1; s.Gra = 1; s.Rin = 1; exp_q.push_back(s);
      end else begin
        s = blank(); s.Zlowout = 1; s.MARin = 1; exp_q.push_back(s);
        if (op == 5'd0) begin
          for (int i = 0; i < lat; i++) begin s = blank(); s.memoryRead = 1; exp_q.push_back(s); end
          s = blank(); s.read = 1; s.MDRin = 1; exp_q.push_back(s);
          s = blank(); s.MDRout = 1; s.Gra = 1; s.Rin = 1; exp_q.push_back(s);
        end else begin
          s = blank(); s.Gra = 1; s.Rout = 1; s.MDRin = 1; exp_q.push_back(s);
          s = blank(); s.memoryWrite = 1; exp_q.push_back(s);
        end
      end
    end else begin
      case (op)
        5'd15, 5'd16: begin
          s = blank(); s.Gra = 1; s.Rout = 1; s.RYin = 1; exp_q.push_back(s);
          s = blank(); s.Grb = 1; s.Rout = 1; s.alu = op; s.Zlowin = 1; s.Zhighin = 1; exp_q.push_back(s);
          s = blank(); s.Zlowout = 1; s.LOin = 1; exp_q.push_back(s);
          s = blank(); s.Zhighout = 1; s.HIin = 1; exp_q.push_back(s);
        end
        5'd17, 5'd18: begin
          s = blank(); s.Grb = 1; s.Rout = 1; s.alu = op; s.Zlowin = 1; exp_q.push_back(s);
          s = blank(); s.Zlowout = 1; s.Gra = 1; s.Rin = 1; exp_q.push_back(s);
        end
        5'd19: begin
          s = blank(); s.Gra = 1; s.Rout = 1; s.CONin = 1; exp_q.push_back(s);
          s = blank(); s.PCout = 1; s.RYin = 1; exp_q.push_back(s);
          s = blank(); s.Cout = 1; s.alu = 5'b00011; s.Zlowin = 1; exp_q.push_back(s);
          s = blank(); s.Zlowout = c; s.PCin = c; exp_q.push_back(s);
        end
        5'd20: begin s = blank(); s.Gra = 1; s.Rout = 1; s.PCin = 1; exp_q.push_back(s); end
        5'd22: begin s = blank(); s.InPortout = 1; s.Gra = 1; s.Rin = 1; exp_q.push_back(s); end
        5'd24, 5'd25: begin
          s = blank(); s.HIout = (op == 5'd24); s.LOout = (op == 5'd25); s.Gra = 1; s.Rin = 1;
          exp_q.push_back(s);
        end
        5'd26: ;
        default: halts = 1'b1;
      endcase
    end
    return halts;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus tasks. All start and end 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic do_clr(input int n);
    strobes_t s;
    clr  = 1'b1;
    stop = 1'b0;
    repeat (n) begin
      @(negedge clk);
      s = obs();
      s.run = 1'b0;
      check("clr_strobes", s, '0);
      @(posedge clk); #1;
    end
    clr = 1'b0;
    model_count = 32'd0;
  endtask

  // Runs one instruction cycle by cycle against the model. stop is asserted
  // from cycle stop_from onwards (-1: never), or randomly when rand_stop=1.
  task automatic run_instr(input logic [31:0] ir_v, input bit con_v, input int stop_from,
                           input bit rand_stop, output bit halted);
    bit dec_halt;
    bit sv = 1'b0;
    dec_halt = build(ir_v[31:27], sel ? 3 : 1, con_v);
    ir  = ir_v;
    con = con_v;
    foreach (exp_q[i]) begin
      if (rand_stop) sv = ($urandom_range(0, 3) == 0);
      else           sv = (stop_from >= 0 && i >= stop_from);
      stop = sv;
      @(negedge clk);
      check($sformatf("op%0d_L%0d_step%0d", ir_v[31:27], sel ? 3 : 1, i), obs(), exp_q[i]);
      check($sformatf("op%0d_count%0d", ir_v[31:27], i), obs_cnt(), model_count);
      @(posedge clk); #1;
    end
    stop   = 1'b0;
    halted = dec_halt || sv;
    if (!dec_halt) model_count = model_count + 32'd1;
    if (halted) begin
      @(negedge clk);
      check("halt_strobes", obs(), '0);
      check("halt_count", obs_cnt(), model_count);
      @(posedge clk); #1;
    end
  endtask

  // Counts cycles from T0 until the next T0 or until run drops.
  task automatic measure(input logic [31:0] ir_v, input bit con_v,
                         output int cycles, output bit halted, output logic [31:0] end_cnt);
    strobes_t s;
    ir = ir_v; con = con_v; stop = 1'b0;
    cycles = -1; halted = 1'b0; end_cnt = '0;
    for (int n = 0; n < 40 && cycles < 0; n++) begin
      @(negedge clk);
      s = obs();
      if (!s.run) begin cycles = n; halted = 1'b1; end_cnt = obs_cnt(); end
      else if (n > 0 && s.PCout && s.pc_increment) begin cycles = n; end_cnt = obs_cnt(); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    strobes_t    e;
    bit          h;
    int          cyc;
    logic [31:0] ec;

    vecs.push_back('{32'h1A920000, 1'b0,  7,  9, 1'b0});  // add
    vecs.push_back('{32'h20000000, 1'b0,  7,  9, 1'b0});  // sub
    vecs.push_back('{32'h68000000, 1'b0,  7,  9, 1'b0});  // andi
    vecs.push_back('{32'h08800005, 1'b0,  7,  9, 1'b0});  // ldi
    vecs.push_back('{32'h00800065, 1'b0, 10, 14, 1'b0});  // ld
    vecs.push_back('{32'h10800010, 1'b0,  9, 11, 1'b0});  // st
    vecs.push_back('{32'h80000000, 1'b0,  8, 10, 1'b0});  // mul
    vecs.push_back('{32'h78000000, 1'b0,  8, 10, 1'b0});  // div
    vecs.push_back('{32'h88000000, 1'b0,  6,  8, 1'b0});  // neg
    vecs.push_back('{32'h99800023, 1'b1,  8, 10, 1'b0});  // br taken
    vecs.push_back('{32'h99800023, 1'b0,  8, 10, 1'b0});  // br not taken
    vecs.push_back('{32'hA0000000, 1'b0,  5,  7, 1'b0});  // jr
    vecs.push_back('{32'hB0000000, 1'b0,  5,  7, 1'b0});  // in
    vecs.push_back('{32'hC0000000, 1'b0,  5,  7, 1'b0});  // mfhi
    vecs.push_back('{32'hD0000000, 1'b0,  4,  6, 1'b0});  // nop
    vecs.push_back('{32'hD8000000, 1'b0,  4,  6, 1'b1});  // halt
    vecs.push_back('{32'hA8000000, 1'b0,  4,  6, 1'b1});  // unlisted 10101
    vecs.push_back('{32'hF8000000, 1'b0,  4,  6, 1'b1});  // unlisted 11111

    clr = 1'b1; ir = '0; con = 1'b0; stop = 1'b0; sel = 1'b0; model_count = '0;
    #1;

    // Reset: clr for two cycles, then both instances sit in T0 with count 0.
    do_clr(2);
    @(negedge clk);
    e = blank(); e.PCout = 1; e.MARin = 1; e.pc_increment = 1;
    check("reset_t0_L1", g_dut[0].o, e);
    check("reset_t0_L3", g_dut[1].o, e);
    check("reset_cnt_L1", g_dut[0].cnt, 32'd0);
    check("reset_cnt_L3", g_dut[1].cnt, 32'd0);
    @(posedge clk); #1;

    // Directed sequences.
    sel = 1'b0; do_clr(1);
    run_instr(32'h1A920000, 1'b0, -1, 1'b0, h);     // add r5,r2,r4
    sel = 1'b1; do_clr(1);
    run_instr(32'h00800065, 1'b0, -1, 1'b0, h);     // ld r1,0x65(r0), 3-cycle memory
    sel = 1'b0; do_clr(1);
    run_instr(32'h99800023, 1'b1, -1, 1'b0, h);     // brzr taken
    run_instr(32'h99800023, 1'b0, -1, 1'b0, h);     // brzr not taken
    run_instr(32'hD8000000, 1'b0, -1, 1'b0, h);     // halt
    check("halt_flag", h, 1'b1);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      check($sformatf("halt_hold%0d", i), obs(), '0);
      @(posedge clk); #1;
    end
    do_clr(1);
    run_instr(32'hD0000000, 1'b0, -1, 1'b0, h);     // nop from T0 after clr

    // stop raised at T5 and held: the add finishes, counts, then halts.
    run_instr(32'h1A920000, 1'b0, 5, 1'b0, h);
    check("stop_halt", h, 1'b1);
    do_clr(1);

    // clr at T5 of a second add: back to T0 with the count cleared.
    run_instr(32'h1A920000, 1'b0, -1, 1'b0, h);
    void'(build(5'd3, 1, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort_step%0d", i), obs(), exp_q[i]);
      @(posedge clk); #1;
    end
    check("abort_pre_cnt", obs_cnt(), 32'd1);
    do_clr(1);
    @(negedge clk);
    e = blank(); e.PCout = 1; e.MARin = 1; e.pc_increment = 1;
    check("abort_t0", obs(), e);
    check("abort_cnt", obs_cnt(), 32'd0);
    @(posedge clk); #1;

    // Table: instruction length and retire behaviour for both latencies.
    foreach (vecs[k]) begin
      for (int s = 0; s < 2; s++) begin
        sel = (s == 1);
        do_clr(1);
        measure(vecs[k].ir, vecs[k].con, cyc, h, ec);
        check($sformatf("vec%0d_L%0d_cycles", k, s ? 3 : 1), cyc, s ? vecs[k].cyc3 : vecs[k].cyc1);
        check($sformatf("vec%0d_L%0d_halted", k, s ? 3 : 1), h, vecs[k].halts);
        check($sformatf("vec%0d_L%0d_count", k, s ? 3 : 1), ec, vecs[k].halts ? 32'd0 : 32'd1);
      end
    end

    // Random instruction streams with random con and stop.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      do_clr(1);
      for (int n = 0; n < 40; n++) begin
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), -1, 1'b1, h);
        if (h) do_clr(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore FSM directly upstream of the Mini SRC datapath.
- Decodes the instruction register and sequences the fetch and execute steps.
- Drives every datapath control strobe: register select/enable, bus drivers, ALU op, memory read/write, PC increment.
- Also tracks run/halt status and counts retired instructions.

Parameters:
MEM_LATENCY, 1, wait cycles that memoryRead is held before memory data is valid at the MDR mux (1..4).

Ports:
clk  input  1  clock, rising edge.
clr  input  1  synchronous active-high reset.
ir  input  32  IR contents from datapath; opcode = ir[31:27].
con  input  1  CON_FF result; valid the cycle after a CONin step.
stop  input  1  request halt at next instruction boundary.
Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register select/encode strobes.
MARin, MDRin, IRin, RYin, PCin, HIin, LOin, Zhighin, Zlowin, InPortin, CONin  output  1 each  register load enables.
PCout, MDRout, HIout, LOout, Zhighout, Zlowout, InPortout, Cout  output  1 each  bus drivers; at most one driver asserted per cycle.
pc_increment  output  1  PC += 1.
read  output  1  MDR mux selects memory data.
memoryRead, memoryWrite  output  1 each  RAM strobes.
alu_control  output  5  ALU opcode.
run  output  1  1 while executing; 0 in HALT.
instr_count  output  32  retired instructions, wraps at 2^32.

Behaviour:
- Outputs are decoded combinationally from state (and ir). While clr=1, every strobe is 0.
- On a clr edge, at any state including mid-instruction: next state T0, instr_count=0, run=1, wait counter=0.
- Fetch:
  - T0: PCout, MARin, pc_increment.
  - T1: memoryRead, held MEM_LATENCY cycles by a down-counter.
  - T2: read, MDRin.
  - T3: MDRout, IRin.
- Decode occurs on the T3→T4 edge; ir is stable from T4.
- alu_control is 0 except in the listed ALU steps. ADD=00011, AND=00101, OR=00110; otherwise alu_control = opcode.
- Execute sequences, by opcode:
  - R-type 00011–01011 (add, sub, and, or, ror, rol, shr, shra, shl): T4 Grb Rout RYin; T5 Grc Rout alu=opcode Zlowin; T6 Zlowout Gra Rin.
  - addi/andi/ori 01100/01101/01110: T4 Grb Rout RYin; T5 Cout alu=ADD/AND/OR Zlowin; T6 Zlowout Gra Rin.
  - ldi 00001: T4 Grb Rout BAout RYin; T5 Cout ADD Zlowin; T6 Zlowout Gra Rin.
  - ld 00000: T4–T5 as ldi; T6 Zlowout MARin; T7 memoryRead (MEM_LATENCY cycles); T8 read MDRin; T9 MDRout Gra Rin.
  - st 00010: T4–T5 as ldi; T6 Zlowout MARin; T7 Gra Rout MDRin with read=0; T8 memoryWrite (1 cycle).
  - mul 10000 / div 01111: T4 Gra Rout RYin; T5 Grb Rout alu=opcode Zlowin Zhighin; T6 Zlowout LOin; T7 Zhighout HIin.
  - neg 10001 / not 10010: T4 Grb Rout alu=opcode Zlowin; T5 Zlowout Gra Rin.
  - br 10011: T4 Gra Rout CONin; T5 PCout RYin; T6 Cout ADD Zlowin; T7 Zlowout PCin only if con=1, otherwise no strobes.
  - jr 10100: T4 Gra Rout PCin.
  - in 10110: T4 InPortout Gra Rin.
  - mfhi 11000 / mflo 11001: T4 HIout or LOout, Gra Rin.
  - nop 11010: no execute step.
- Completion of an instruction:
  - On leaving the last step (for nop, T3), instr_count increments.
  - Next state is T0, or HALT if stop=1 on that edge.
- halt 11011 and all unlisted opcodes → HALT with no count increment.
- HALT: all strobes 0, run=0. Only clr exits.
- stop asserted mid-instruction is sampled only at the completion edge. The instruction always finishes.
- Memory wait with MEM_LATENCY=k: exactly k consecutive cycles of memoryRead, then exactly one read+MDRin cycle.

Test Plan:
- clr held 2 cycles, then released → T0 in the cycle after release: PCout=MARin=pc_increment=1, run=1, instr_count=0.
- MEM_LATENCY=1, ir=0x1A920000 (add r5,r2,r4) → cycles 0–6 exactly as fetch T0–T3 plus R-type T4–T6; T5 alu_control=00011, Grc=1; instr_count=1 and state T0 at cycle 7.
- MEM_LATENCY=3, ir=0x00800065 (ld r1,0x65(r0)) → memoryRead high 3 cycles in T1 and 3 cycles in T7; BAout=1 at T4; Gra Rin at T9; 14 cycles total.
- ir=0x99800023 (brzr r3) with con=1 at T7 → Zlowout=PCin=1. Repeat with con=0 → no strobes at T7, next state T0.
- ir=0xD8000000 (halt) → run=0 from cycle 4, strobes stay 0 for 20 cycles; clr → T0.
- stop pulsed at T5 of an add → add completes through T6, then HALT with instr_count incremented. clr asserted at T5 of a second add → T0 next cycle, instr_count=0.
